// File: rtl/bus_arbiter_lv1_lv2.sv
// Round-robin arbiter for the shared lv1-lv2 bus: one proc grant plus a nested snoop slot.
// Optional hold-time watchdog enabled by defining ARB_TIMEOUT_EN.
module bus_arbiter_lv1_lv2 #(
  parameter int NUM_CORES = 4,
  parameter int PTR_WID   = 3,
  parameter int SPTR_WID  = 2,
  parameter int TIMEOUT   = 1023
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [2*NUM_CORES-1:0] bus_lv1_lv2_req_proc,
  output logic [2*NUM_CORES-1:0] bus_lv1_lv2_gnt_proc,
  input  logic [NUM_CORES-1:0]   bus_lv1_lv2_req_snoop,
  output logic [NUM_CORES-1:0]   bus_lv1_lv2_gnt_snoop,
  output logic                   bus_busy,
  output logic [PTR_WID-1:0]     proc_owner,
  output logic                   arb_timeout
);

  localparam int NPROC = 2 * NUM_CORES;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PROC  = 2'd1;
  localparam logic [1:0] SNOOP = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]          state, state_nxt;
  logic [PTR_WID-1:0]  proc_ptr, proc_ptr_nxt, owner_nxt, proc_win, proc_ptr_adv;
  logic [SPTR_WID-1:0] snoop_ptr, snoop_ptr_nxt, snoop_owner, snoop_owner_nxt, snoop_win, snoop_ptr_adv;
  logic [NPROC-1:0]     gnt_proc_nxt;
  logic [NUM_CORES-1:0] gnt_snoop_nxt, snoop_elig;

  // First set bit at or above ptr, wrapping; scanned downward so the nearest one wins.
  function automatic logic [PTR_WID-1:0] pick_proc(input logic [NPROC-1:0] req,
                                                   input logic [PTR_WID-1:0] ptr);
    logic [PTR_WID-1:0] w;
    logic [PTR_WID-1:0] cand;
    w = ptr;
    for (int i = NPROC - 1; i >= 0; i--) begin
      cand = PTR_WID'((int'(ptr) + i) % NPROC);
      if (req[cand]) w = cand;
    end
    return w;
  endfunction

  function automatic logic [SPTR_WID-1:0] pick_snoop(input logic [NUM_CORES-1:0] req,
                                                     input logic [SPTR_WID-1:0] ptr);
    logic [SPTR_WID-1:0] s;
    logic [SPTR_WID-1:0] cand;
    s = ptr;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      cand = SPTR_WID'((int'(ptr) + i) % NUM_CORES);
      if (req[cand]) s = cand;
    end
    return s;
  endfunction

  // The owning core never snoops its own transaction.
  assign snoop_elig    = bus_lv1_lv2_req_snoop & ~(NUM_CORES'(1) << proc_owner[PTR_WID-1:1]);
  assign proc_win      = pick_proc(bus_lv1_lv2_req_proc, proc_ptr);
  assign snoop_win     = pick_snoop(snoop_elig, snoop_ptr);
  assign proc_ptr_adv  = (proc_owner == PTR_WID'(NPROC - 1)) ? '0 : proc_owner + 1'b1;
  assign snoop_ptr_adv = (snoop_owner == SPTR_WID'(NUM_CORES - 1)) ? '0 : snoop_owner + 1'b1;

  always_comb begin
    state_nxt       = state;
    gnt_proc_nxt    = bus_lv1_lv2_gnt_proc;
    gnt_snoop_nxt   = bus_lv1_lv2_gnt_snoop;
    owner_nxt       = proc_owner;
    snoop_owner_nxt = snoop_owner;
    proc_ptr_nxt    = proc_ptr;
    snoop_ptr_nxt   = snoop_ptr;
    case (state)
      IDLE: begin
        if (|bus_lv1_lv2_req_proc) begin
          gnt_proc_nxt = NPROC'(1) << proc_win;
          owner_nxt    = proc_win;
          state_nxt    = PROC;
        end
      end
      PROC: begin
        // A proc release takes priority over a simultaneous snoop request.
        if (!bus_lv1_lv2_req_proc[proc_owner]) begin
          gnt_proc_nxt = '0;
          proc_ptr_nxt = proc_ptr_adv;
          state_nxt    = IDLE;
        end else if (|snoop_elig) begin
          gnt_snoop_nxt   = NUM_CORES'(1) << snoop_win;
          snoop_owner_nxt = snoop_win;
          state_nxt       = SNOOP;
        end
      end
      SNOOP: begin
        if (!bus_lv1_lv2_req_snoop[snoop_owner]) begin
          gnt_snoop_nxt = '0;
          snoop_ptr_nxt = snoop_ptr_adv;
          if (!bus_lv1_lv2_req_proc[proc_owner]) begin
            gnt_proc_nxt = '0;
            proc_ptr_nxt = proc_ptr_adv;
            state_nxt    = IDLE;
          end else begin
            state_nxt = PROC;
          end
        end else if (!bus_lv1_lv2_req_proc[proc_owner]) begin
          state_nxt = DRAIN;
        end
      end
      default: begin
        if (!bus_lv1_lv2_req_snoop[snoop_owner]) begin
          gnt_proc_nxt  = '0;
          gnt_snoop_nxt = '0;
          proc_ptr_nxt  = proc_ptr_adv;
          snoop_ptr_nxt = snoop_ptr_adv;
          state_nxt     = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                 <= IDLE;
      bus_lv1_lv2_gnt_proc  <= '0;
      bus_lv1_lv2_gnt_snoop <= '0;
      proc_owner            <= '0;
      snoop_owner           <= '0;
      proc_ptr              <= '0;
      snoop_ptr             <= '0;
    end else begin
      state                 <= state_nxt;
      bus_lv1_lv2_gnt_proc  <= gnt_proc_nxt;
      bus_lv1_lv2_gnt_snoop <= gnt_snoop_nxt;
      proc_owner            <= owner_nxt;
      snoop_owner           <= snoop_owner_nxt;
      proc_ptr              <= proc_ptr_nxt;
      snoop_ptr             <= snoop_ptr_nxt;
    end
  end

  assign bus_busy = |bus_lv1_lv2_gnt_proc;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_WID = $clog2(TIMEOUT + 1);

  logic [CNT_WID-1:0] hold_cnt;
  logic               timeout_q;
  logic               grant_change;

  assign grant_change = (gnt_proc_nxt != bus_lv1_lv2_gnt_proc) ||
                        (gnt_snoop_nxt != bus_lv1_lv2_gnt_snoop);

  // hold_cnt equals the number of cycles the current grant set has been visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (grant_change) begin
        hold_cnt <= CNT_WID'(1);
      end else if (state != IDLE && hold_cnt != CNT_WID'(TIMEOUT)) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
      if (state != IDLE && !grant_change && hold_cnt == CNT_WID'(TIMEOUT - 1)) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign arb_timeout = timeout_q;
`else
  assign arb_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter_lv1_lv2.sv
// Directed bench for bus_arbiter_lv1_lv2; the timeout scenario runs only with ARB_TIMEOUT_EN.
module tb_bus_arbiter_lv1_lv2;

  logic       clk;
  logic       rst_n;
  logic [7:0] req_proc;
  logic [7:0] gnt_proc;
  logic [3:0] req_snoop;
  logic [3:0] gnt_snoop;
  logic       bus_busy;
  logic [2:0] proc_owner;
  logic       arb_timeout;

  int checks = 0;
  int errors = 0;

  bus_arbiter_lv1_lv2 #(
    .NUM_CORES(4),
    .PTR_WID(3),
    .SPTR_WID(2),
    .TIMEOUT(15)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus_lv1_lv2_req_proc(req_proc),
    .bus_lv1_lv2_gnt_proc(gnt_proc),
    .bus_lv1_lv2_req_snoop(req_snoop),
    .bus_lv1_lv2_gnt_snoop(gnt_snoop),
    .bus_busy(bus_busy),
    .proc_owner(proc_owner),
    .arb_timeout(arb_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive requests just after a falling edge, then return at the next falling edge.
  task automatic applyStimulus(input logic [7:0] p, input logic [3:0] s);
    req_proc  = p;
    req_snoop = s;
    @(negedge clk);
  endtask

  task automatic doReset();
    rst_n     = 1'b0;
    req_proc  = '0;
    req_snoop = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int e;
    rst_n     = 1'b0;
    req_proc  = '0;
    req_snoop = '0;
    @(negedge clk);
    doReset();
    checkOutput("reset_gnt_proc", 32'(gnt_proc), 32'h0);
    checkOutput("reset_gnt_snoop", 32'(gnt_snoop), 32'h0);
    checkOutput("reset_busy", 32'(bus_busy), 32'h0);
    checkOutput("reset_owner", 32'(proc_owner), 32'h0);
    checkOutput("reset_timeout", 32'(arb_timeout), 32'h0);

    $display("[TB] single requester on bit 2");
    for (int k = 0; k < 5; k++) begin
      applyStimulus(8'b0000_0100, 4'b0000);
      checkOutput("single_gnt", 32'(gnt_proc), 32'h04);
    end
    checkOutput("single_owner", 32'(proc_owner), 32'd2);
    checkOutput("single_busy", 32'(bus_busy), 32'h1);
    applyStimulus(8'h00, 4'b0000);
    checkOutput("single_release", 32'(gnt_proc), 32'h0);
    checkOutput("single_idle_busy", 32'(bus_busy), 32'h0);
    applyStimulus(8'h00, 4'b0000);
    checkOutput("single_stay_idle", 32'(gnt_proc), 32'h0);

    $display("[TB] round robin with all requesters");
    doReset();
    e = 0;
    for (int g = 0; g < 9; g++) begin
      for (int k = 0; k < 3; k++) begin
        applyStimulus(8'hFF, 4'b0000);
        checkOutput("rr_gnt", 32'(gnt_proc), 32'(8'h01 << e));
      end
      checkOutput("rr_owner", 32'(proc_owner), 32'(e));
      applyStimulus(8'hFF & ~(8'h01 << e), 4'b0000);
      checkOutput("rr_turnaround", 32'(gnt_proc), 32'h0);
      e = (e + 1) % 8;
    end

    $display("[TB] nested snoop with owner masked");
    applyStimulus(8'h01, 4'b0000);
    checkOutput("snp_proc_gnt", 32'(gnt_proc), 32'h01);
    applyStimulus(8'h01, 4'b0011);
    checkOutput("snp_gnt", 32'(gnt_snoop), 32'h2);
    checkOutput("snp_proc_held", 32'(gnt_proc), 32'h01);
    applyStimulus(8'h01, 4'b0011);
    checkOutput("snp_gnt_held", 32'(gnt_snoop), 32'h2);
    applyStimulus(8'h01, 4'b0001);
    checkOutput("snp_release", 32'(gnt_snoop), 32'h0);
    checkOutput("snp_proc_after", 32'(gnt_proc), 32'h01);
    applyStimulus(8'h01, 4'b0001);
    checkOutput("snp_owner_masked", 32'(gnt_snoop), 32'h0);

    $display("[TB] proc drop while snoop active");
    applyStimulus(8'h01, 4'b0100);
    checkOutput("drain_snp_gnt", 32'(gnt_snoop), 32'h4);
    applyStimulus(8'h00, 4'b0100);
    checkOutput("drain_proc_held", 32'(gnt_proc), 32'h01);
    checkOutput("drain_snp_held", 32'(gnt_snoop), 32'h4);
    applyStimulus(8'h00, 4'b0100);
    checkOutput("drain_proc_wait", 32'(gnt_proc), 32'h01);
    applyStimulus(8'h00, 4'b0000);
    checkOutput("drain_proc_clr", 32'(gnt_proc), 32'h0);
    checkOutput("drain_snp_clr", 32'(gnt_snoop), 32'h0);

    $display("[TB] reset during snoop");
    applyStimulus(8'h08, 4'b0000);
    checkOutput("rst_pre_gnt", 32'(gnt_proc), 32'h08);
    checkOutput("rst_pre_owner", 32'(proc_owner), 32'd3);
    applyStimulus(8'h08, 4'b0001);
    checkOutput("rst_pre_snp", 32'(gnt_snoop), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_async_proc", 32'(gnt_proc), 32'h0);
    checkOutput("rst_async_snp", 32'(gnt_snoop), 32'h0);
    checkOutput("rst_async_busy", 32'(bus_busy), 32'h0);
    req_proc  = '0;
    req_snoop = '0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(8'hFF, 4'b0000);
    checkOutput("rst_restart_gnt", 32'(gnt_proc), 32'h01);
    checkOutput("rst_restart_owner", 32'(proc_owner), 32'd0);
    applyStimulus(8'h00, 4'b0000);
    checkOutput("rst_restart_rel", 32'(gnt_proc), 32'h0);

`ifdef ARB_TIMEOUT_EN
    $display("[TB] hold timeout");
    checkOutput("to_before", 32'(arb_timeout), 32'h0);
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(8'h10, 4'b0000);
      checkOutput("to_gnt", 32'(gnt_proc), 32'h10);
      checkOutput("to_flag", 32'(arb_timeout), (k >= 15) ? 32'h1 : 32'h0);
    end
    applyStimulus(8'h00, 4'b0000);
    checkOutput("to_release", 32'(gnt_proc), 32'h0);
    checkOutput("to_sticky", 32'(arb_timeout), 32'h1);
`else
    for (int k = 0; k < 3; k++) begin
      applyStimulus(8'h10, 4'b0000);
      checkOutput("to_disabled", 32'(arb_timeout), 32'h0);
    end
    applyStimulus(8'h00, 4'b0000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
